// File: rtl/light_pingpong_buffer_pkg.sv
// Shared constants and types for the light ping-pong buffer and the LED driver stage.
package light_pingpong_buffer_pkg;

   localparam int LIGHT_DATA_W = 16;
   localparam int LIGHT_IDX_W  = 9;
   localparam int DROP_CNT_W   = 8;

   typedef logic [LIGHT_IDX_W-1:0]  light_idx_t;
   typedef logic [LIGHT_DATA_W-1:0] light_val_t;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/light_pingpong_buffer_bank.sv
// One frame bank: simple dual-port RAM with registered read, written to map onto block RAM.
module light_bank_ram #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 9
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**IDX_W];
   logic [DATA_W-1:0] rd_data_q;

   // No reset on the array or read register so the tools keep this as block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/light_pingpong_buffer.sv
// Double-buffered light map between the video writer and the LED driver reader.
// Optional saturating dropped-frame counter enabled by LIGHT_BUF_DROP_CNT_EN.
module light_pingpong_buffer
   import light_pingpong_buffer_pkg::*;
#(
   parameter int DATA_W = LIGHT_DATA_W,
   parameter int IDX_W  = LIGHT_IDX_W
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_frame_done,
   input  logic              rd_sync,
   input  logic [IDX_W-1:0]  rd_index,
   output logic [DATA_W-1:0] rd_data,
   output logic              light_refresh,
`ifdef LIGHT_BUF_DROP_CNT_EN
   output logic              frame_valid,
   output logic [DROP_CNT_W-1:0] drop_cnt
`else
   output logic              frame_valid
`endif
);

   logic wb_q, wb_d;
   logic pending_q, pending_d;
   logic frame_valid_q, frame_valid_d;
   logic refresh_q, refresh_d;
   logic rd_sel_q, rd_sel_d;
   logic rd_vld_q, rd_vld_d;
   logic swap;
   logic [DATA_W-1:0] bank0_rd, bank1_rd;

   assign swap = rd_sync & (pending_q | wr_frame_done);

   // rd_sel/rd_vld remember which bank was addressed and whether it was presentable
   // at the read edge, so a read issued in a swap cycle still returns the old bank.
   always_comb begin
      wb_d          = wb_q ^ swap;
      pending_d     = pending_q;
      if (swap)               pending_d = 1'b0;
      else if (wr_frame_done) pending_d = 1'b1;
      frame_valid_d = frame_valid_q | swap;
      refresh_d     = swap;
      rd_sel_d      = ~wb_q;
      rd_vld_d      = frame_valid_q;
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         wb_q          <= 1'b0;
         pending_q     <= 1'b0;
         frame_valid_q <= 1'b0;
         refresh_q     <= 1'b0;
         rd_sel_q      <= 1'b1;
         rd_vld_q      <= 1'b0;
      end else begin
         wb_q          <= wb_d;
         pending_q     <= pending_d;
         frame_valid_q <= frame_valid_d;
         refresh_q     <= refresh_d;
         rd_sel_q      <= rd_sel_d;
         rd_vld_q      <= rd_vld_d;
      end
   end

   light_bank_ram #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_bank0 (
      .clk     (I_clk),
      .wr_en   (wr_en & ~wb_q),
      .wr_addr (wr_index),
      .wr_data (wr_data),
      .rd_addr (rd_index),
      .rd_data (bank0_rd)
   );

   light_bank_ram #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_bank1 (
      .clk     (I_clk),
      .wr_en   (wr_en & wb_q),
      .wr_addr (wr_index),
      .wr_data (wr_data),
      .rd_addr (rd_index),
      .rd_data (bank1_rd)
   );

   assign rd_data       = rd_vld_q ? (rd_sel_q ? bank1_rd : bank0_rd) : '0;
   assign light_refresh = refresh_q;
   assign frame_valid   = frame_valid_q;

`ifdef LIGHT_BUF_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // A frame completing while one is still pending overwrites the unread frame.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (wr_frame_done && pending_q) drop_cnt_d = sat_inc(drop_cnt_q);
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
`endif

endmodule

// File: tb/tb_light_pingpong_buffer.sv
// Directed self-checking bench for light_pingpong_buffer (with or without LIGHT_BUF_DROP_CNT_EN).
module tb_light_pingpong_buffer;
   import light_pingpong_buffer_pkg::*;

   localparam int DW = LIGHT_DATA_W;
   localparam int IW = LIGHT_IDX_W;

   logic          I_clk = 1'b0;
   logic          I_rst;
   logic          wr_en;
   logic [IW-1:0] wr_index;
   logic [DW-1:0] wr_data;
   logic          wr_frame_done;
   logic          rd_sync;
   logic [IW-1:0] rd_index;
   logic [DW-1:0] rd_data;
   logic          light_refresh;
   logic          frame_valid;
`ifdef LIGHT_BUF_DROP_CNT_EN
   logic [7:0]    drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   light_pingpong_buffer dut (
      .I_clk         (I_clk),
      .I_rst         (I_rst),
      .wr_en         (wr_en),
      .wr_index      (wr_index),
      .wr_data       (wr_data),
      .wr_frame_done (wr_frame_done),
      .rd_sync       (rd_sync),
      .rd_index      (rd_index),
      .rd_data       (rd_data),
      .light_refresh (light_refresh),
`ifdef LIGHT_BUF_DROP_CNT_EN
      .frame_valid   (frame_valid),
      .drop_cnt      (drop_cnt)
`else
      .frame_valid   (frame_valid)
`endif
   );

   always #5 I_clk = ~I_clk;

   typedef struct {
      string         name;
      logic          fdone;
      logic          sync;
      logic [IW-1:0] ridx;
      logic          exp_ref;
      logic          exp_val;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_frame_done = 0; rd_sync = 0;
   endtask

   task automatic wr(input int idx, input int data);
      wr_en = 1; wr_index = IW'(idx); wr_data = DW'(data);
      tick();
      wr_en = 0;
   endtask

   task automatic chk_out(input string name, input logic r, input logic v, input logic [DW-1:0] d);
      chk({name, ".refresh"}, 32'(light_refresh), 32'(r));
      chk({name, ".valid"},   32'(frame_valid),   32'(v));
      chk({name, ".rd_data"}, 32'(rd_data),       32'(d));
   endtask

   task automatic run_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         idle();
         wr_frame_done = vecs[i].fdone;
         rd_sync       = vecs[i].sync;
         rd_index      = vecs[i].ridx;
         tick();
         chk_out(vecs[i].name, vecs[i].exp_ref, vecs[i].exp_val, vecs[i].exp_rd);
      end
      idle();
   endtask

   task automatic chk_drop(input string name, input int exp);
`ifdef LIGHT_BUF_DROP_CNT_EN
      chk(name, 32'(drop_cnt), 32'(exp));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //             name            done sync ridx  ref val rd
      vecs[0] = '{"nopend_sync",   0, 1, 9'd0,   0, 0, 16'h0000};
      vecs[1] = '{"nopend_after",  0, 0, 9'd0,   0, 0, 16'h0000};
      vecs[2] = '{"f1_done",       1, 0, 9'd5,   0, 0, 16'h0000};
      vecs[3] = '{"f1_swap",       0, 1, 9'd5,   1, 1, 16'h0000};
      vecs[4] = '{"f1_rd5",        0, 0, 9'd5,   0, 1, 16'h0005};
      vecs[5] = '{"f1_rd511",      0, 0, 9'd511, 0, 1, 16'h01FF};
      vecs[6] = '{"f1_sync_idle",  0, 1, 9'd1,   0, 1, 16'h0001};

      I_rst = 1; idle(); wr_index = '0; wr_data = '0; rd_index = '0;
      #2;
      chk_out("reset", 0, 0, 16'h0000);
      chk_drop("reset.drop", 0);
      tick(); tick();
      I_rst = 0;
      tick();

      // rd_sync with nothing pending
      run_vecs(0, 1);

      // full frame with data = index, then swap in
      for (int i = 0; i < 512; i++) wr(i, i);
      run_vecs(2, 6);

      // two completed frames before a sync: one drop, newer data wins
      for (int i = 0; i < 16; i++) wr(i, 16'h5000 + i);
      wr_frame_done = 1; tick(); idle();
      for (int i = 0; i < 16; i++) wr(i, 16'hA000 + i);
      wr_frame_done = 1; tick(); idle();
      chk_drop("drop_one", 1);
      rd_index = 3; tick();
      chk_out("pre_swap_rd3", 0, 1, 16'h0003);
      rd_sync = 1; tick(); idle();
      chk_out("f2_swap", 1, 1, 16'h0003);
      tick();
      chk_out("f2_rd3", 0, 1, 16'hA003);

      // frame done and sync together; same-cycle write goes to the old write bank
      wr(3, 16'hD003);
      wr_en = 1; wr_index = 4; wr_data = 16'hD004;
      wr_frame_done = 1; rd_sync = 1; rd_index = 3;
      tick(); idle();
      chk_out("coinc_swap", 1, 1, 16'hA003);
      tick();
      chk_out("coinc_new3", 0, 1, 16'hD003);
      rd_index = 4; tick();
      chk_out("coinc_new4", 0, 1, 16'hD004);
      rd_sync = 1; tick(); idle();
      chk_out("coinc_nopend", 0, 1, 16'hD004);
      chk_drop("coinc_drop", 1);

      // reset in the middle of writing the next frame
      for (int i = 0; i < 4; i++) wr(i, 16'hE000 + i);
      rd_index = 3;
      @(posedge I_clk); #3;
      I_rst = 1;
      #1;
      chk_out("midrst", 0, 0, 16'h0000);
      chk_drop("midrst.drop", 0);
      #2; I_rst = 0;
      tick();
      chk_out("post_rst_rd", 0, 0, 16'h0000);
      rd_sync = 1; tick(); idle();
      chk_out("post_rst_sync", 0, 0, 16'h0000);
      wr(3, 16'h7777);
      wr_frame_done = 1; tick(); idle();
      chk_drop("post_rst_done", 0);
      rd_sync = 1; tick(); idle();
      chk_out("post_rst_swap", 1, 1, 16'h0000);
      tick();
      chk_out("post_rst_rd3", 0, 1, 16'h7777);

      // saturation of the drop counter
      wr_frame_done = 1; tick(); idle();
      chk_drop("sat_start", 0);
      for (int k = 1; k <= 256; k++) begin
         wr_frame_done = 1; tick(); idle();
         if (k == 1)   chk_drop("sat_1", 1);
         if (k == 254) chk_drop("sat_254", 254);
         if (k == 255) chk_drop("sat_255", 255);
         if (k == 256) chk_drop("sat_256", 255);
      end
      rd_sync = 1; tick(); idle();
      chk("sat_swap_refresh", 32'(light_refresh), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/light_pingpong_buffer.md
LIGHT_PINGPONG_BUFFER -- requirements
Module: light_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of one mapped light value.
REQ-002 SHALL have parameter IDX_W, default 9, meaning index width; each bank holds 2**IDX_W entries (512).
REQ-003 SHALL have port I_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port I_rst, input, 1, an asynchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1, meaning the write strobe from the video side.
REQ-006 SHALL have port wr_index, input, IDX_W, meaning the write address.
REQ-007 SHALL have port wr_data, input, DATA_W, meaning the mapped light value to store.
REQ-008 SHALL have port wr_frame_done, input, 1, a one-cycle pulse meaning the current write frame is complete.
REQ-009 SHALL have port rd_sync, input, 1, a one-cycle pulse from the LED driver meaning it is at a scan-frame boundary.
REQ-010 SHALL have port rd_index, input, IDX_W, meaning the driver read address (the driver's light_index).
REQ-011 SHALL have port rd_data, output, DATA_W, meaning the read value (the driver's mapped_light).
REQ-012 SHALL have port light_refresh, output, 1, a one-cycle pulse meaning a new frame is now readable.
REQ-013 SHALL have port frame_valid, output, 1, meaning at least one frame has been swapped in since reset.

Function
REQ-014 SHALL contain two banks, each 2**IDX_W x DATA_W; the register wb selects the write bank and bank ~wb is the read bank.
REQ-015 SHALL, when wr_en=1, write wr_data to bank wb at wr_index at that clock edge, using wb before any same-cycle swap.
REQ-016 SHALL keep flag pending: set by wr_frame_done, cleared by a swap.
REQ-017 SHALL swap (toggle wb, clear pending) at the edge where rd_sync=1 and (pending=1 or wr_frame_done=1).
REQ-018 SHALL, when wr_frame_done and rd_sync coincide, swap in that just-completed frame in the same cycle.
REQ-019 SHALL ignore rd_sync when no frame is pending: no swap, and no light_refresh pulse.
REQ-020 SHALL, on wr_frame_done while pending=1, leave pending=1 and count a dropped frame (see REQ-030); the newer data overwrites the same bank.
REQ-021 SHALL pulse light_refresh high for exactly one cycle, in the cycle after a swap edge.
REQ-022 SHALL set frame_valid at the first swap and hold it until reset.
REQ-023 SHALL give rd_data one-cycle read latency: the value at bank (~wb) at rd_index, sampled at edge N, appears after edge N.
REQ-024 SHALL output rd_data=0 while frame_valid=0.
REQ-025 SHALL, for a read issued in the swap cycle, return data from the pre-swap read bank.
REQ-026 SHALL treat index wrap-around as plain modulo 2**IDX_W with no range check.

Reset
REQ-027 SHALL, while I_rst=1, asynchronously force wb=0, pending=0, frame_valid=0, light_refresh=0, rd_data=0 and drop_cnt=0.
REQ-028 SHALL not clear bank contents on reset; the contents are unreadable until the first swap anyway (REQ-024).
REQ-029 SHALL, on reset mid-frame, abandon the partially written frame; the next wr_frame_done after reset starts the count afresh.

Configuration
REQ-030 SHALL, with macro LIGHT_BUF_DROP_CNT_EN defined, add output drop_cnt [7:0], a saturating count of REQ-020 events that saturates at 255.
REQ-031 SHALL, without LIGHT_BUF_DROP_CNT_EN, have neither the drop_cnt port nor its counter logic; all other behaviour is identical.

Structure
REQ-032 SHALL take the defaults of DATA_W and IDX_W from a shared package as constants, alongside the index type, which the driver stage also uses.
REQ-033 SHALL implement each bank as one sub-module, light_bank_ram (simple dual-port, registered read), instantiated twice; it SHALL be inferable as block RAM.

Verification
REQ-034 Bench SHALL check: write indices 0..511 with data = index, pulse wr_frame_done, then pulse rd_sync -> light_refresh pulses one cycle later; reading index 5 returns 0x0005 and index 511 returns 0x01FF.
REQ-035 Bench SHALL check: pulse rd_sync with no pending frame -> no swap, light_refresh stays 0, rd_data stays 0, frame_valid stays 0.
REQ-036 Bench SHALL check: two wr_frame_done pulses (second frame data = 0xA000+index) before any rd_sync -> drop_cnt=1; after rd_sync, index 3 reads 0xA003.
REQ-037 Bench SHALL check: wr_frame_done and rd_sync in the same cycle -> a swap in that cycle, pending=0 afterwards, and a read at that edge returns the old bank's data.
REQ-038 Bench SHALL check: assert I_rst mid-write of frame 2 after frame 1 has been swapped in -> frame_valid=0, rd_data=0, drop_cnt=0 immediately; frame 1 is no longer presented.
REQ-039 Bench SHALL check: 256 consecutive drop events -> drop_cnt holds at 255.
